// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request encodings and loader FSM states.
// Used by both the instruction encoder/loader and the main decoder.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [1:0] {
      CLS_LW    = 2'b00,
      CLS_SW    = 2'b01,
      CLS_RTYPE = 2'b10,
      CLS_BEQ   = 2'b11
   } instr_class_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } load_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer: request fields -> RV32I machine word plus illegal flag.
module instr_encoder
   import riscv_pkg::*;
(
   input  logic [1:0]  cls,
   input  logic [2:0]  alu,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   logic [2:0] funct3;
   logic [6:0] funct7;

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      funct3  = F3_ADD_SUB;
      funct7  = F7_BASE;
      case (cls)
         CLS_LW: word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
         CLS_SW: word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
         CLS_RTYPE: begin
            // Reserved ALU codes fall back to ADD and are flagged.
            case (alu)
               ALU_ADD: funct3 = F3_ADD_SUB;
               ALU_SUB: funct7 = F7_SUB;
               ALU_AND: funct3 = F3_AND;
               ALU_OR:  funct3 = F3_OR;
               ALU_SLT: funct3 = F3_SLT;
               default: illegal = 1'b1;
            endcase
            word = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
         end
         CLS_BEQ: begin
            word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
            illegal = imm[0];
         end
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot loader: encodes host requests and streams them into imem at sequential
// word addresses, holding the core in reset until the session completes.
module instr_encoder_loader
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [1:0]                     in_class,
   input  logic [2:0]                     in_alu,
   input  logic [4:0]                     in_rd,
   input  logic [4:0]                     in_rs1,
   input  logic [4:0]                     in_rs2,
   input  logic [12:0]                    in_imm,
   input  logic                           in_last,
   output logic                           imem_we,
   output logic [31:0]                    imem_addr,
   output logic [31:0]                    imem_wdata,
   output logic                           cpu_rst,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(DEPTH_WORDS):0]   count,
   output logic                           err_overflow,
   output logic                           err_illegal
);

   localparam int unsigned CW = $clog2(DEPTH_WORDS) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH_WORDS);

   load_state_e state, state_next;

   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        accept;
   logic        overflow;
   logic        session_start;

   instr_encoder u_encoder (
      .cls     (in_class),
      .alu     (in_alu),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign accept        = in_valid && in_ready;
   assign overflow      = (state == ST_LOAD) && in_valid && (count == DEPTH_CNT);
   assign session_start = start && ((state == ST_IDLE) || (state == ST_DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_LOAD;
         ST_LOAD:  if ((accept && in_last) || overflow) state_next = ST_DRAIN;
         ST_DRAIN: state_next = ST_DONE;
         ST_DONE:  if (start) state_next = ST_LOAD;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == ST_LOAD) && (count < DEPTH_CNT);
      busy     = (state == ST_LOAD) || (state == ST_DRAIN);
      done     = (state == ST_DONE);
      cpu_rst  = (state != ST_DONE);
   end

   // count tracks accepted words so in_ready never lets one past the limit
   // while the matching write is still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_we      <= 1'b0;
         imem_addr    <= BASE_ADDR;
         imem_wdata   <= '0;
         count        <= '0;
         err_overflow <= 1'b0;
         err_illegal  <= 1'b0;
      end else begin
         imem_we <= accept;
         if (accept) imem_wdata <= enc_word;
         if (session_start) begin
            imem_addr    <= BASE_ADDR;
            count        <= '0;
            err_overflow <= 1'b0;
            err_illegal  <= 1'b0;
         end else begin
            if (imem_we)               imem_addr    <= imem_addr + 32'd4;
            if (accept)                count        <= count + CW'(1);
            if (overflow)              err_overflow <= 1'b1;
            if (accept && enc_illegal) err_illegal  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table plus multi-cycle
// session, overflow, restart and mid-load reset sequences.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_class;
   logic [2:0]  in_alu;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [12:0] in_imm;
   logic        in_last;
   logic        imem_we;
   logic [31:0] imem_addr, imem_wdata;
   logic        cpu_rst, busy, done;
   logic [2:0]  count;
   logic        err_overflow, err_illegal;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  cls;
      logic [2:0]  alu;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      logic [31:0] word;
      logic        ill;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   instr_encoder_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_class     (in_class),
      .in_alu       (in_alu),
      .in_rd        (in_rd),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_imm       (in_imm),
      .in_last      (in_last),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst      (cpu_rst),
      .busy         (busy),
      .done         (done),
      .count        (count),
      .err_overflow (err_overflow),
      .err_illegal  (err_illegal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] c, input logic [2:0] a, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im,
                          input logic last);
      in_valid = 1'b1;
      in_class = c;
      in_alu   = a;
      in_rd    = d;
      in_rs1   = s1;
      in_rs2   = s2;
      in_imm   = im;
      in_last  = last;
   endtask

   // One-request session starting from IDLE or DONE.
   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      start = 1'b1;
      tick();
      start = 1'b0;
      set_req(v.cls, v.alu, v.rd, v.rs1, v.rs2, v.imm, 1'b1);
      chk($sformatf("vec%0d ready", idx), {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d we", idx), {31'b0, imem_we}, 32'd1);
      chk($sformatf("vec%0d wdata", idx), imem_wdata, v.word);
      chk($sformatf("vec%0d addr", idx), imem_addr, 32'h0);
      tick();
      chk($sformatf("vec%0d done", idx), {31'b0, done}, 32'd1);
      chk($sformatf("vec%0d cpu_rst", idx), {31'b0, cpu_rst}, 32'd0);
      chk($sformatf("vec%0d count", idx), {29'b0, count}, 32'd1);
      chk($sformatf("vec%0d illegal", idx), {31'b0, err_illegal}, {31'b0, v.ill});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{2'b00, 3'b000, 5'd6,  5'd9,  5'd0,  13'h0FFC, 32'hFFC4A303, 1'b0};
      vecs[1]  = '{2'b01, 3'b000, 5'd0,  5'd9,  5'd6,  13'h0008, 32'h0064A423, 1'b0};
      vecs[2]  = '{2'b10, 3'b011, 5'd4,  5'd5,  5'd6,  13'h0000, 32'h0062E233, 1'b0};
      vecs[3]  = '{2'b10, 3'b001, 5'd2,  5'd3,  5'd4,  13'h0000, 32'h40418133, 1'b0};
      vecs[4]  = '{2'b11, 3'b000, 5'd0,  5'd4,  5'd4,  13'h1FF8, 32'hFE420CE3, 1'b0};
      vecs[5]  = '{2'b11, 3'b000, 5'd0,  5'd4,  5'd4,  13'h1FF9, 32'hFE420CE3, 1'b1};
      vecs[6]  = '{2'b10, 3'b010, 5'd1,  5'd2,  5'd3,  13'h0000, 32'h003170B3, 1'b0};
      vecs[7]  = '{2'b10, 3'b101, 5'd10, 5'd11, 5'd12, 13'h0000, 32'h00C5A533, 1'b0};
      vecs[8]  = '{2'b10, 3'b110, 5'd1,  5'd1,  5'd1,  13'h0000, 32'h001080B3, 1'b1};
      vecs[9]  = '{2'b01, 3'b000, 5'd7,  5'd1,  5'd2,  13'h1FFC, 32'hFE20AE23, 1'b0};
      vecs[10] = '{2'b00, 3'b000, 5'd31, 5'd0,  5'd31, 13'h0800, 32'h80002F83, 1'b0};
      vecs[11] = '{2'b11, 3'b000, 5'd5,  5'd1,  5'd2,  13'h0010, 32'h00208863, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      set_req(2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 13'h0, 1'b0);
      in_valid = 1'b0;
      #3;
      chk("rst we", {31'b0, imem_we}, 32'd0);
      chk("rst addr", imem_addr, 32'h0);
      chk("rst wdata", imem_wdata, 32'h0);
      chk("rst count", {29'b0, count}, 32'd0);
      chk("rst cpu_rst", {31'b0, cpu_rst}, 32'd1);
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst errs", {30'b0, err_overflow, err_illegal}, 32'd0);
      chk("rst ready", {31'b0, in_ready}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) run_vec(i);

      // Back-to-back SW, OR, SUB(last) with a stray start while busy.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b busy", {31'b0, busy}, 32'd1);
      set_req(2'b01, 3'b000, 5'd0, 5'd9, 5'd6, 13'h0008, 1'b0);
      tick();
      chk("b2b w0 we", {31'b0, imem_we}, 32'd1);
      chk("b2b w0 data", imem_wdata, 32'h0064A423);
      chk("b2b w0 addr", imem_addr, 32'h0);
      set_req(2'b10, 3'b011, 5'd4, 5'd5, 5'd6, 13'h0000, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b w1 we", {31'b0, imem_we}, 32'd1);
      chk("b2b w1 data", imem_wdata, 32'h0062E233);
      chk("b2b w1 addr", imem_addr, 32'h4);
      set_req(2'b10, 3'b001, 5'd2, 5'd3, 5'd4, 13'h0000, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("b2b w2 we", {31'b0, imem_we}, 32'd1);
      chk("b2b w2 data", imem_wdata, 32'h40418133);
      chk("b2b w2 addr", imem_addr, 32'h8);
      chk("b2b drain busy", {31'b0, busy}, 32'd1);
      tick();
      chk("b2b we off", {31'b0, imem_we}, 32'd0);
      chk("b2b done", {31'b0, done}, 32'd1);
      chk("b2b cpu_rst", {31'b0, cpu_rst}, 32'd0);
      chk("b2b count", {29'b0, count}, 32'd3);

      // Overflow: five requests offered, none marked last.
      start = 1'b1;
      tick();
      start = 1'b0;
      set_req(2'b00, 3'b000, 5'd1, 5'd2, 5'd0, 13'h0004, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("ovf w%0d we", k), {31'b0, imem_we}, 32'd1);
         chk($sformatf("ovf w%0d addr", k), imem_addr, 32'(4 * k));
      end
      chk("ovf count4", {29'b0, count}, 32'd4);
      chk("ovf ready low", {31'b0, in_ready}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("ovf no 5th write", {31'b0, imem_we}, 32'd0);
      chk("ovf flag", {31'b0, err_overflow}, 32'd1);
      chk("ovf drain", {31'b0, busy}, 32'd1);
      tick();
      chk("ovf done", {31'b0, done}, 32'd1);
      chk("ovf count held", {29'b0, count}, 32'd4);

      // Start in DONE clears counters and flags.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart count", {29'b0, count}, 32'd0);
      chk("restart ovf clr", {31'b0, err_overflow}, 32'd0);
      chk("restart addr", imem_addr, 32'h0);
      chk("restart busy", {31'b0, busy}, 32'd1);

      // Reset after two writes in LOAD.
      set_req(2'b00, 3'b000, 5'd3, 5'd4, 5'd0, 13'h0000, 1'b0);
      tick();
      tick();
      in_valid = 1'b0;
      chk("mid w1 addr", imem_addr, 32'h4);
      tick();
      chk("mid count2", {29'b0, count}, 32'd2);
      rst = 1'b1;
      #1;
      chk("mid rst we", {31'b0, imem_we}, 32'd0);
      chk("mid rst busy", {31'b0, busy}, 32'd0);
      chk("mid rst cpu_rst", {31'b0, cpu_rst}, 32'd1);
      chk("mid rst count", {29'b0, count}, 32'd0);
      chk("mid rst addr", imem_addr, 32'h0);
      #2;
      rst = 1'b0;
      run_vec(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
